// File: rtl/fetch_decode_ctrl_pkg.sv
// Shared definitions for the fetch/decode sequencing controller:
// state encoding and the default bubble instruction word.
package fd_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_RUN    = 3'd0,
        ST_WAIT   = 3'd1,
        ST_SQUASH = 3'd2,
        ST_HALT   = 3'd3,
        ST_ERR    = 3'd4
    } fd_state_e;

    localparam logic [15:0] NOP_INSTR_DEF = 16'h0800;

endpackage

// File: rtl/fetch_decode_ctrl_sat_counter.sv
// Saturating up-counter with synchronous active-low reset; holds at
// all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt <= '0;
        end else if (inc && (cnt != {W{1'b1}})) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/fetch_decode_ctrl.sv
// Fetch/Decode sequencing: drives PC and F/D enables around a multi-cycle
// instruction memory, handling wait states, load-use holds, squashes, HALT and errors.
module fetch_decode_ctrl
    import fd_ctrl_pkg::*;
#(
    parameter logic [15:0] NOP_INSTR = NOP_INSTR_DEF,
    parameter int          CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             imem_stall,
    input  logic             imem_done,
    input  logic             imem_err,
    input  logic             ld_use_hz,
    input  logic             br_redirect,
    input  logic             halt_dec,
    output logic             imem_rd,
    output logic             pc_we,
    output logic             fd_we,
    output logic             fd_bubble,
    output logic             fd_valid,
    output logic             halted,
    output logic             err,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [15:0]      fd_nop,
    output logic [2:0]       fsm_state
);

    fd_state_e state, state_nxt;

    logic active;
    logic take_err, take_br, take_halt, take_hold, take_cap;

    // Priority chain, shared by next-state and output logic so they cannot disagree.
    always_comb begin
        active    = rst && ((state == ST_RUN) || (state == ST_WAIT) || (state == ST_SQUASH));
        take_err  = active && imem_err;
        take_br   = active && !imem_err && br_redirect;
        take_halt = active && !imem_err && !br_redirect && halt_dec && fd_valid;
        take_hold = active && (state != ST_SQUASH) && !imem_err && !br_redirect
                    && !(halt_dec && fd_valid) && ld_use_hz;
        take_cap  = active && (state != ST_SQUASH) && !imem_err && !br_redirect
                    && !(halt_dec && fd_valid) && !ld_use_hz && imem_done;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= ST_RUN;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (take_err) begin
            state_nxt = ST_ERR;
        end else if (take_br) begin
            // A redirect while a fetch is still in flight must drop that fetch's data.
            if (state == ST_SQUASH) begin
                state_nxt = imem_done ? ST_RUN : ST_SQUASH;
            end else begin
                state_nxt = imem_stall ? ST_SQUASH : ST_RUN;
            end
        end else if (take_halt) begin
            state_nxt = ST_HALT;
        end else if (active && (state == ST_SQUASH)) begin
            state_nxt = imem_done ? ST_RUN : ST_SQUASH;
        end else if (take_hold) begin
            state_nxt = imem_done ? ST_RUN : state;
        end else if (take_cap) begin
            state_nxt = ST_RUN;
        end else if (active && imem_stall) begin
            state_nxt = ST_WAIT;
        end
    end

    always_comb begin
        imem_rd   = 1'b0;
        pc_we     = 1'b0;
        fd_we     = 1'b0;
        fd_bubble = 1'b0;
        if (active) begin
            imem_rd = 1'b1;
            if (take_err) begin
                imem_rd = 1'b1;
            end else if (take_br) begin
                pc_we     = 1'b1;
                fd_we     = 1'b1;
                fd_bubble = 1'b1;
            end else if (take_hold) begin
                fd_we = 1'b0;
            end else if (take_cap) begin
                pc_we = 1'b1;
                fd_we = 1'b1;
            end else begin
                fd_we     = 1'b1;
                fd_bubble = 1'b1;
            end
        end else if (rst && (state == ST_HALT)) begin
            fd_we     = 1'b1;
            fd_bubble = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            fd_valid <= 1'b0;
            halted   <= 1'b0;
            err      <= 1'b0;
        end else begin
            if (fd_we) begin
                fd_valid <= !fd_bubble;
            end
            halted <= halted | take_halt;
            err    <= err | take_err;
        end
    end

    sat_counter #(
        .W(CNT_W)
    ) u_stall_cnt (
        .clk (clk),
        .rst (rst),
        .inc (active && !pc_we),
        .cnt (stall_cnt)
    );

    // The datapath takes its bubble word from here so there is a single source for it.
    assign fd_nop    = NOP_INSTR;
    assign fsm_state = state;

endmodule

// File: tb/tb_fetch_decode_ctrl.sv
// Directed bench for fetch_decode_ctrl; a narrow-counter twin shares the
// stimulus so saturation is reached in a few cycles.
module tb_fetch_decode_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_stall, imem_done, imem_err, ld_use_hz, br_redirect, halt_dec;
    logic        imem_rd, pc_we, fd_we, fd_bubble, fd_valid, halted, err;
    logic [15:0] stall_cnt;
    logic [15:0] fd_nop;
    logic [2:0]  fsm_state;

    logic        s_imem_rd, s_pc_we, s_fd_we, s_fd_bubble, s_fd_valid, s_halted, s_err;
    logic [2:0]  s_stall_cnt;
    logic [15:0] s_fd_nop;
    logic [2:0]  s_fsm_state;

    int checks = 0;
    int errors = 0;

    localparam logic [2:0] RUN = 3'd0, WAIT = 3'd1, SQUASH = 3'd2, HALT = 3'd3, ERR = 3'd4;

    always #5 clk = ~clk;

    fetch_decode_ctrl #(.NOP_INSTR(16'h0800), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .imem_stall(imem_stall), .imem_done(imem_done),
        .imem_err(imem_err), .ld_use_hz(ld_use_hz), .br_redirect(br_redirect),
        .halt_dec(halt_dec), .imem_rd(imem_rd), .pc_we(pc_we), .fd_we(fd_we),
        .fd_bubble(fd_bubble), .fd_valid(fd_valid), .halted(halted), .err(err),
        .stall_cnt(stall_cnt), .fd_nop(fd_nop), .fsm_state(fsm_state)
    );

    fetch_decode_ctrl #(.NOP_INSTR(16'h0800), .CNT_W(3)) dut_s (
        .clk(clk), .rst(rst), .imem_stall(imem_stall), .imem_done(imem_done),
        .imem_err(imem_err), .ld_use_hz(ld_use_hz), .br_redirect(br_redirect),
        .halt_dec(halt_dec), .imem_rd(s_imem_rd), .pc_we(s_pc_we), .fd_we(s_fd_we),
        .fd_bubble(s_fd_bubble), .fd_valid(s_fd_valid), .halted(s_halted), .err(s_err),
        .stall_cnt(s_stall_cnt), .fd_nop(s_fd_nop), .fsm_state(s_fsm_state)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One cycle: apply inputs {stall,done,ld,br,halt,err}, check {rd,pc_we,fd_we,bubble}
    // mid-cycle, then advance past the next rising edge.
    task automatic step(input string tag, input logic st, input logic dn, input logic ld,
                        input logic br, input logic hd, input logic er, input logic [3:0] exp_ctl);
        imem_stall  = st;
        imem_done   = dn;
        ld_use_hz   = ld;
        br_redirect = br;
        halt_dec    = hd;
        imem_err    = er;
        @(negedge clk);
        check(tag, {28'd0, imem_rd, pc_we, fd_we, fd_bubble}, {28'd0, exp_ctl});
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0;
        // Reset: combinational outputs forced low even with a completed fetch presented.
        step("rst_ctl0", 0, 1, 0, 0, 0, 0, 4'b0000);
        step("rst_ctl1", 0, 1, 1, 1, 1, 1, 4'b0000);
        check("rst_fd_valid", fd_valid, 0);
        check("rst_halted", halted, 0);
        check("rst_err", err, 0);
        check("rst_cnt", stall_cnt, 0);
        check("rst_state", fsm_state, RUN);
        check("nop_word", fd_nop, 16'h0800);
        rst = 1'b1;

        // Three single-cycle fetches.
        step("fetch1", 0, 1, 0, 0, 0, 0, 4'b1110);
        check("fetch1_valid", fd_valid, 1);
        step("fetch2", 0, 1, 0, 0, 0, 0, 4'b1110);
        step("fetch3", 0, 1, 0, 0, 0, 0, 4'b1110);
        check("fetch_cnt", stall_cnt, 0);

        // Three wait states, then capture.
        step("wait1", 1, 0, 0, 0, 0, 0, 4'b1011);
        check("wait1_state", fsm_state, WAIT);
        check("wait1_valid", fd_valid, 0);
        step("wait2", 1, 0, 0, 0, 0, 0, 4'b1011);
        step("wait3", 1, 0, 0, 0, 0, 0, 4'b1011);
        step("wait_done", 0, 1, 0, 0, 0, 0, 4'b1110);
        check("wait_state", fsm_state, RUN);
        check("wait_valid", fd_valid, 1);
        check("wait_cnt", stall_cnt, 3);

        // Load-use hold then normal capture.
        step("ld_hold", 0, 1, 1, 0, 0, 0, 4'b1000);
        check("ld_valid", fd_valid, 1);
        check("ld_cnt", stall_cnt, 4);
        step("ld_refetch", 0, 1, 0, 0, 0, 0, 4'b1110);
        check("ld_refetch_cnt", stall_cnt, 4);

        // Redirect on the 2nd wait cycle, squashed completion, then clean fetch.
        step("sq_wait", 1, 0, 0, 0, 0, 0, 4'b1011);
        step("sq_br", 1, 0, 0, 1, 0, 0, 4'b1111);
        check("sq_state", fsm_state, SQUASH);
        check("sq_valid", fd_valid, 0);
        check("sq_cnt", stall_cnt, 5);
        step("sq_stall", 1, 0, 0, 0, 0, 0, 4'b1011);
        check("sq_cnt6", stall_cnt, 6);
        check("sat_cnt6", s_stall_cnt, 6);
        step("sq_drop", 0, 1, 0, 0, 0, 0, 4'b1011);
        check("sq_drop_state", fsm_state, RUN);
        check("sq_drop_valid", fd_valid, 0);
        check("sat_cnt7", s_stall_cnt, 7);
        step("sq_target", 0, 1, 0, 0, 0, 0, 4'b1110);
        check("sq_target_valid", fd_valid, 1);

        // HALT in decode.
        step("halt_det", 0, 1, 0, 0, 1, 0, 4'b1011);
        check("halt_state", fsm_state, HALT);
        check("halted", halted, 1);
        check("halt_cnt", stall_cnt, 8);
        check("sat_hold", s_stall_cnt, 7);
        step("halt_idle", 0, 1, 0, 1, 1, 0, 4'b0011);
        check("halt_sticky", halted, 1);
        check("halt_cnt_frozen", stall_cnt, 8);

        rst = 1'b0;
        step("rst2_ctl", 0, 0, 0, 0, 0, 0, 4'b0000);
        check("rst2_halted", halted, 0);
        check("rst2_cnt", stall_cnt, 0);
        check("rst2_state", fsm_state, RUN);
        check("rst2_sat_cnt", s_stall_cnt, 0);
        rst = 1'b1;

        // HALT on the wrong path: redirect wins.
        step("hb_fetch", 0, 1, 0, 0, 0, 0, 4'b1110);
        step("hb_both", 0, 1, 0, 1, 1, 0, 4'b1111);
        check("hb_state", fsm_state, RUN);
        check("hb_halted", halted, 0);
        check("hb_valid", fd_valid, 0);
        step("hb_target", 0, 1, 0, 0, 0, 0, 4'b1110);

        // Memory error during a wait state.
        step("err_wait", 1, 0, 0, 0, 0, 0, 4'b1011);
        step("err_hit", 1, 0, 0, 0, 0, 1, 4'b1000);
        check("err_flag", err, 1);
        check("err_state", fsm_state, ERR);
        check("err_cnt", stall_cnt, 2);
        step("err_idle", 0, 1, 0, 1, 1, 0, 4'b0000);
        step("err_idle2", 1, 0, 1, 0, 0, 0, 4'b0000);
        check("err_sticky", err, 1);
        check("err_cnt_frozen", stall_cnt, 2);

        rst = 1'b0;
        step("rst3_ctl", 1, 0, 0, 0, 0, 0, 4'b0000);
        check("rst3_err", err, 0);
        check("rst3_state", fsm_state, RUN);
        rst = 1'b1;
        step("rst3_fetch", 0, 1, 0, 0, 0, 0, 4'b1110);
        check("rst3_valid", fd_valid, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
